// File: rtl/mapper_konami_gen_if.sv
// rtl/mapper_konami_gen_if.sv - slot-side access bus and registered SDRAM-side results of the Konami mapper
interface mapper_konami_gen_if #(
  parameter int ADDR_W = 27
);
  logic              mreq;
  logic              req;
  logic              rd;
  logic              wr;
  logic [15:0]       addr;
  logic [7:0]        data_in;
  logic [ADDR_W-1:0] out_addr;
  logic              ram_cs;
  logic              scc_cs;
  logic              bank_wr;

  modport master (
    output mreq, req, rd, wr, addr, data_in,
    input  out_addr, ram_cs, scc_cs, bank_wr
  );

  modport slave (
    input  mreq, req, rd, wr, addr, data_in,
    output out_addr, ram_cs, scc_cs, bank_wr
  );
endinterface

// File: rtl/mapper_konami_gen.sv
// rtl/mapper_konami_gen.sv - Konami / Konami-SCC MegaROM bank mapper with per-instance bank sets
module mapper_konami_gen #(
  parameter int NUM_ID    = 2,
  parameter int BANK_BITS = 8,
  parameter int PAGE_BITS = 13,
  parameter int ADDR_W    = 27,
  parameter int MIRROR    = 1,
  localparam int ID_W     = (NUM_ID > 1) ? $clog2(NUM_ID) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           mode,
  input  logic [ID_W-1:0]      id,
  input  logic [ADDR_W-1:0]    rom_size,
  mapper_konami_gen_if.slave   bus
);

  // Per-instance bank registers and SCC enables
  logic [BANK_BITS-1:0] bank_q [NUM_ID][4];
  logic [BANK_BITS-1:0] bank_d [NUM_ID][4];
  logic [NUM_ID-1:0]    scc_en_q, scc_en_d;

  // Registered outputs
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              ram_cs_q, ram_cs_d;
  logic              scc_cs_q, scc_cs_d;
  logic              bank_wr_q, bank_wr_d;

  // Decode helpers
  logic                 mode_kon, mode_scc, id_ok, access, is_write, is_read;
  logic                 in_window, scc_hit, wr_hit, mapped;
  logic [ID_W-1:0]      sel;
  logic [1:0]           page, wr_idx;
  logic [BANK_BITS-1:0] page_bank;
  logic [ADDR_W-1:0]    rom_addr, rom_final;

  assign mode_kon  = (mode == 2'd1);
  assign mode_scc  = (mode == 2'd2);
  assign id_ok     = (32'(id) < NUM_ID);
  assign sel       = id_ok ? id : '0;
  assign access    = bus.mreq & bus.req & (mode_kon | mode_scc) & id_ok & (bus.rd | bus.wr);
  // A simultaneous rd+wr is a write; only a pure rd reads ROM.
  assign is_write  = bus.wr;
  assign is_read   = bus.rd & ~bus.wr;
  // 4000-BFFF is the only ROM window; A15^A14 is 1 exactly there.
  assign in_window = bus.addr[15] ^ bus.addr[14];
  // Page 0..3 maps to 4000/6000/8000/A000, i.e. A[15:13] minus 2.
  assign page      = {~bus.addr[14], bus.addr[13]};
  // Plain Konami has no bank 0 register: page 4000 always reads ROM bank 0.
  assign page_bank = (mode_kon && page == 2'd0) ? '0 : bank_q[sel][page];
  assign rom_addr  = ADDR_W'({page_bank, bus.addr[PAGE_BITS-1:0]});
  assign scc_hit   = mode_scc && scc_en_q[sel] && (bus.addr[15:8] == 8'h98);

  generate
    if (MIRROR != 0) begin : g_mirror
      assign rom_final = rom_addr & (rom_size - ADDR_W'(1));
      assign mapped    = in_window;
    end else begin : g_bound
      assign rom_final = rom_addr;
      assign mapped    = in_window && (rom_addr < rom_size);
    end
  endgenerate

  // Bank-register write decode for the active mapper flavour
  always_comb begin
    wr_hit = 1'b0;
    wr_idx = 2'd0;
    if (mode_kon) begin
      case (bus.addr[15:13])
        3'b011:  begin wr_hit = 1'b1; wr_idx = 2'd1; end
        3'b100:  begin wr_hit = 1'b1; wr_idx = 2'd2; end
        3'b101:  begin wr_hit = 1'b1; wr_idx = 2'd3; end
        default: ;
      endcase
    end else if (mode_scc) begin
      case (bus.addr[15:11])
        5'b01010: begin wr_hit = 1'b1; wr_idx = 2'd0; end
        5'b01110: begin wr_hit = 1'b1; wr_idx = 2'd1; end
        5'b10010: begin wr_hit = 1'b1; wr_idx = 2'd2; end
        5'b10110: begin wr_hit = 1'b1; wr_idx = 2'd3; end
        default:  ;
      endcase
    end
  end

  // Next-state: bank updates, SCC enable tracking, and next-cycle output values
  always_comb begin
    bank_d     = bank_q;
    scc_en_d   = scc_en_q;
    out_addr_d = '1;
    ram_cs_d   = 1'b0;
    scc_cs_d   = 1'b0;
    bank_wr_d  = 1'b0;
    if (access) begin
      scc_cs_d = scc_hit;
      if (is_write) begin
        if (wr_hit) begin
          bank_d[sel][wr_idx] = bus.data_in[BANK_BITS-1:0];
          bank_wr_d           = 1'b1;
          if (mode_scc && wr_idx == 2'd2) begin
            scc_en_d[sel] = (bus.data_in[5:0] == 6'h3F);
          end
        end
      end else if (is_read && mapped && !scc_hit) begin
        ram_cs_d   = 1'b1;
        out_addr_d = rom_final;
      end
    end
    // The SCC window only exists in SCC mode; leaving it disarms every instance.
    if (!mode_scc) begin
      scc_en_d = '0;
    end
  end

  // State and output registers; reset restores banks {0,1,2,3} and idle outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ID; i++) begin
        for (int j = 0; j < 4; j++) begin
          bank_q[i][j] <= BANK_BITS'(j);
        end
      end
      scc_en_q   <= '0;
      out_addr_q <= '1;
      ram_cs_q   <= 1'b0;
      scc_cs_q   <= 1'b0;
      bank_wr_q  <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      scc_en_q   <= scc_en_d;
      out_addr_q <= out_addr_d;
      ram_cs_q   <= ram_cs_d;
      scc_cs_q   <= scc_cs_d;
      bank_wr_q  <= bank_wr_d;
    end
  end

  assign bus.out_addr = out_addr_q;
  assign bus.ram_cs   = ram_cs_q;
  assign bus.scc_cs   = scc_cs_q;
  assign bus.bank_wr  = bank_wr_q;

endmodule
